// File: rtl/stage_wb.sv
// Write-back stage: commits memory-stage results into the register file and serves decode reads.
// Reads/forwarding are combinational (write-through bypass); commit lands on the next edge; no backpressure.
module stage_wb #(
  parameter int BUS_W = 32,
  parameter int REG_N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       wdOp_in,
  input  logic [BUS_W-1:0] memResult_in,
  input  logic             retire_in,
  input  logic [4:0]       rs1Addr_in,
  input  logic [4:0]       rs2Addr_in,
  output logic [BUS_W-1:0] rs1Data_out,
  output logic [BUS_W-1:0] rs2Data_out,
  output logic             fwdEn_out,
  output logic [4:0]       fwdAddr_out,
  output logic [BUS_W-1:0] fwdData_out,
  output logic [4:0]       lastRd_out,
  output logic [BUS_W-1:0] lastData_out,
  output logic [63:0]      instret_out
);

  logic [4:0]       rd;
  logic             commit;
  logic [BUS_W-1:0] regs [REG_N];
  logic [63:0]      instret_q;
  logic [4:0]       last_rd_q;
  logic [BUS_W-1:0] last_data_q;

  assign rd     = wdOp_in[5:1];
  assign commit = wdOp_in[0] && (rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rd] <= memResult_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q   <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else begin
      if (retire_in) instret_q <= instret_q + 64'd1;
      if (commit) begin
        last_rd_q   <= rd;
        last_data_q <= memResult_in;
      end
    end
  end

  // x0 and reset force zero; an in-flight commit to the same rd wins over the stale array entry
  function automatic logic [BUS_W-1:0] read_port(input logic [4:0] addr);
    logic [BUS_W-1:0] val;
    val = '0;
    if (!rst && addr != 5'd0) begin
      if (commit && addr == rd) val = memResult_in;
      else                      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    rs1Data_out = read_port(rs1Addr_in);
    rs2Data_out = read_port(rs2Addr_in);
  end

  assign fwdEn_out    = commit && !rst;
  assign fwdAddr_out  = commit ? rd : 5'd0;
  assign fwdData_out  = commit ? memResult_in : '0;
  assign lastRd_out   = last_rd_q;
  assign lastData_out = last_data_q;
  assign instret_out  = instret_q;

endmodule

// File: tb/tb_stage_wb.sv
// Testbench for stage_wb: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a register-file model.
module tb_stage_wb;

  logic        clk;
  logic        rst;
  logic [5:0]  wdOp_in;
  logic [31:0] memResult_in;
  logic        retire_in;
  logic [4:0]  rs1Addr_in, rs2Addr_in;
  logic [31:0] rs1Data_out, rs2Data_out;
  logic        fwdEn_out;
  logic [4:0]  fwdAddr_out;
  logic [31:0] fwdData_out;
  logic [4:0]  lastRd_out;
  logic [31:0] lastData_out;
  logic [63:0] instret_out;

  stage_wb #(.BUS_W(32), .REG_N(32)) dut (
    .clk(clk), .rst(rst), .wdOp_in(wdOp_in), .memResult_in(memResult_in),
    .retire_in(retire_in), .rs1Addr_in(rs1Addr_in), .rs2Addr_in(rs2Addr_in),
    .rs1Data_out(rs1Data_out), .rs2Data_out(rs2Data_out), .fwdEn_out(fwdEn_out),
    .fwdAddr_out(fwdAddr_out), .fwdData_out(fwdData_out), .lastRd_out(lastRd_out),
    .lastData_out(lastData_out), .instret_out(instret_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: architectural view of the register file and commit history
  logic [31:0] m_regs [32];
  logic [63:0] m_instret   = '0;
  logic [4:0]  m_last_rd   = '0;
  logic [31:0] m_last_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_instret   = '0;
      m_last_rd   = '0;
      m_last_data = '0;
    end else begin
      if (wdOp_in[0] && wdOp_in[5:1] != 0) begin
        m_regs[wdOp_in[5:1]] = memResult_in;
        m_last_rd   = wdOp_in[5:1];
        m_last_data = memResult_in;
      end
      if (retire_in) m_instret = m_instret + 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (rst || a == 0) return 32'd0;
    if (wdOp_in[0] && wdOp_in[5:1] != 0 && a == wdOp_in[5:1]) return memResult_in;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    logic c;
    c = wdOp_in[0] && (wdOp_in[5:1] != 0);
    chk("rs1_data", rs1Data_out, exp_read(rs1Addr_in));
    chk("rs2_data", rs2Data_out, exp_read(rs2Addr_in));
    chk("fwd_en", fwdEn_out, c && !rst);
    chk("fwd_addr", fwdAddr_out, c ? wdOp_in[5:1] : 5'd0);
    chk("fwd_data", fwdData_out, c ? memResult_in : 32'd0);
    chk("last_rd", lastRd_out, m_last_rd);
    chk("last_data", lastData_out, m_last_data);
    chk("instret", instret_out, m_instret);
  end

  // Drive one cycle's inputs just after the rising edge, then let combinational outputs settle
  task automatic step(input logic [5:0] wd, input logic [31:0] d, input logic ret,
                      input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    wdOp_in = wd; memResult_in = d; retire_in = ret; rs1Addr_in = a1; rs2Addr_in = a2;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wdOp_in = 6'b000011; memResult_in = 32'hDEADBEEF; retire_in = 1'b1;
    rs1Addr_in = 5'd0; rs2Addr_in = 5'd0;
    #1 rst = 1'b1;

    // Reset held for 3 cycles with a pending write to x1 and retire asserted
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      rs1Addr_in = a[4:0];
      #1;
      if (rs1Data_out != 0) chk("rst_read", rs1Data_out, 32'd0);
      else total++;
    end
    chk("rst_fwd_en", fwdEn_out, 1'b0);
    chk("rst_instret", instret_out, 64'd0);
    chk("rst_last_rd", lastRd_out, 5'd0);
    rst = 1'b0; wdOp_in = 6'd0; retire_in = 1'b0; rs1Addr_in = 5'd1;
    step(6'd0, 32'd0, 1'b0, 5'd1, 5'd0);
    chk("x1_after_rst", rs1Data_out, 32'd0);

    // Basic commit: bypass in the commit cycle, array in the next
    step({5'd5, 1'b1}, 32'h12345678, 1'b0, 5'd5, 5'd0);
    chk("commit_bypass", rs1Data_out, 32'h12345678);
    chk("commit_fwd_addr", fwdAddr_out, 5'd5);
    step(6'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    chk("commit_array", rs1Data_out, 32'h12345678);
    chk("commit_last_rd", lastRd_out, 5'd5);
    chk("commit_last_data", lastData_out, 32'h12345678);

    // Write to x0 is discarded
    step({5'd0, 1'b1}, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    chk("x0_rs1", rs1Data_out, 32'd0);
    chk("x0_rs2", rs2Data_out, 32'd0);
    chk("x0_fwd_en", fwdEn_out, 1'b0);
    step(6'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("x0_last_rd", lastRd_out, 5'd5);

    // Back-to-back overwrite of x7 with both ports hitting the bypass
    step({5'd7, 1'b1}, 32'hA, 1'b0, 5'd0, 5'd0);
    step({5'd7, 1'b1}, 32'hB, 1'b0, 5'd7, 5'd7);
    chk("b2b_rs1", rs1Data_out, 32'hB);
    chk("b2b_rs2", rs2Data_out, 32'hB);
    step(6'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    chk("b2b_array", rs1Data_out, 32'hB);

    // Five retires with write-enable low
    repeat (5) step({5'd9, 1'b0}, 32'hCAFEF00D, 1'b1, 5'd9, 5'd0);
    step(6'd0, 32'd0, 1'b0, 5'd9, 5'd0);
    chk("retire5_count", instret_out, 64'd5);
    chk("retire5_x9", rs1Data_out, 32'd0);

    // Counter wrap from a preloaded value
    step(6'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    step(6'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    chk("wrap_max", instret_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(6'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("wrap_zero", instret_out, 64'd0);

    // Reset asserted mid-cycle after a commit to x3
    step({5'd3, 1'b1}, 32'h55, 1'b1, 5'd3, 5'd0);
    step(6'd0, 32'd0, 1'b1, 5'd3, 5'd0);
    chk("mid_pre_x3", rs1Data_out, 32'h55);
    rst = 1'b1;
    #1;
    chk("mid_rst_x3", rs1Data_out, 32'd0);
    chk("mid_rst_instret", instret_out, 64'd0);
    step(6'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(6'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    chk("mid_post_x3", rs1Data_out, 32'd0);

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0]  r, a1, a2;
      logic        en;
      r  = 5'($urandom_range(0, 31));
      en = ($urandom_range(0, 9) < 7);
      a1 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
      step({r, en}, $urandom, 1'($urandom_range(0, 1)), a1, a2);
      rst = ($urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    step(6'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Write-back stage, directly downstream of the memory stage.
- Consumes the registered write-back op (wdOp) and result word produced by the memory stage, and commits them into the integrated 32 x BUS_W architectural register file.
- Serves the decode stage's two combinational read ports, with write-through bypass.
- Also exports a same-cycle forwarding path, a last-commit debug record and a 64-bit retired-instruction counter.

Parameters:
- BUS_W, 32, datapath width; must match the `BUS_W` define in RVX_Info.v.
- REG_N, 32, number of architectural registers; address width is fixed at 5 bits.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- wdOp_in  in  6  write-back op from the memory stage: [0] = write enable, [5:1] = destination register rd.
- memResult_in  in  BUS_W  result word from the memory stage (load data or ALU result).
- retire_in  in  1  one instruction leaves the pipeline this cycle.
- rs1Addr_in  in  5  decode read port 1 address.
- rs2Addr_in  in  5  decode read port 2 address.
- rs1Data_out  out  BUS_W  read port 1 data (combinational).
- rs2Data_out  out  BUS_W  read port 2 data (combinational).
- fwdEn_out  out  1  a non-x0 write is being committed this cycle.
- fwdAddr_out  out  5  rd of that write.
- fwdData_out  out  BUS_W  data of that write.
- lastRd_out  out  5  rd of the most recent committed write (registered).
- lastData_out  out  BUS_W  data of the most recent committed write (registered).
- instret_out  out  64  retired-instruction count (registered).

Behaviour:
- Commit condition:
  - commit = wdOp_in[0] && (wdOp_in[5:1] != 0).
  - On a rising clk edge with commit, regs[rd] <= memResult_in.
  - Writes to x0 are discarded and produce no forwarding or last-commit update.
- Read ports:
  - rsNData_out = 0 when rsNAddr_in == 0.
  - Otherwise, if commit and rsNAddr_in == rd, output memResult_in (write-through bypass, zero latency).
  - Otherwise output regs[rsNAddr_in].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Forwarding outputs are purely combinational:
  - fwdEn_out = commit && !rst.
  - fwdAddr_out = commit ? rd : 0.
  - fwdData_out = commit ? memResult_in : 0.
- Last-commit record: on a commit edge, lastRd_out <= rd and lastData_out <= memResult_in; otherwise both hold.
- Retire counter:
  - On an edge with retire_in = 1, instret_out increments by 1, independent of commit.
  - Wraps from 2^64-1 to 0 with no flag.
- Write latency: data written at edge N is visible from the register array in cycle N+1. In cycle N it is already visible via the bypass.
- Reset (asynchronous, active-high, effective immediately with no clock needed):
  - All regs[1..31] cleared to 0.
  - lastRd_out = 0, lastData_out = 0, instret_out = 0.
  - While rst is high: fwdEn_out = 0, read ports return 0 for any address, and no write or count occurs.
  - A write present at the clock edge coinciding with rst high is lost.
  - On deassertion, the first commit happens at the first rising edge with rst low.
- Simultaneous events: commit and retire in the same cycle both take effect. A read of rd during its commit returns the new value, never the stale one.
- x0 always reads 0, regardless of writes or bypass.

Test Plan:
- Reset values: hold rst=1 for 3 cycles with wdOp_in=6'b000011, memResult_in=32'hDEADBEEF, retire_in=1 -> rs1Data_out=0 for every address, fwdEn_out=0, instret_out=0, lastRd_out=0; regs[1] still 0 after release.
- Basic commit: wdOp_in={5'd5,1'b1}, memResult_in=32'h12345678 for 1 cycle, then wdOp_in=0; set rs1Addr_in=5 -> rs1Data_out=32'h12345678 in both the commit cycle (bypass) and the following cycle (array); lastRd_out=5.
- x0 protection: wdOp_in={5'd0,1'b1}, memResult_in=32'hFFFFFFFF; rs1Addr_in=rs2Addr_in=0 -> both outputs 0, fwdEn_out=0, lastRd_out unchanged.
- Back-to-back overwrite with dual bypass: write x7=32'hA, next cycle write x7=32'hB with rs1Addr_in=rs2Addr_in=7 -> both ports read 32'hB in the second cycle; regs[7] reads 32'hB afterwards.
- Counter wrap: preload instret via 2^64-2 retire cycles or force, then drive 2 retire cycles -> instret_out steps 2^64-1, then 0. Also check that 5 retires with wdOp_in[0]=0 give instret_out=5 and no register change.
- Reset mid-operation: commit x3=32'h55 at edge N, assert rst asynchronously mid-cycle N+1 -> rs1Data_out for x3 and instret_out drop to 0 before the next edge; after release, x3 reads 0.
